// File: rtl/div_pkg.sv
// Shared constants for the sequential repeated-subtraction divider.
// Holds the state encoding and the default operand width.
package div_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider: one compare/subtract per clock, quotient counted up.
// A zero divisor short-circuits to DONE with an all-ones quotient and the flag set.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy,
    output logic         done
);

    div_state_t   state_reg;
    logic [N-1:0] rem_w;
    logic [N-1:0] quo_w;
    logic [N-1:0] div_w;

    // busy and done are registered copies of the state being entered, so they
    // line up exactly with state_reg without any combinational decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rem_w       <= '0;
            quo_w       <= '0;
            div_w       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_w <= divisor;
                        rem_w <= dividend;
                        quo_w <= '0;
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_reg   <= S_DONE;
                        end else begin
                            state_reg <= S_CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end

                S_CALC: begin
                    busy <= 1'b1;
                    // The guard ensures the subtraction never borrows and quo_w
                    // tops out at 2^N-1 (dividend all ones, divisor one).
                    if (rem_w >= div_w) begin
                        rem_w <= rem_w - div_w;
                        quo_w <= quo_w + 1'b1;
                        done  <= 1'b0;
                    end else begin
                        quotient    <= quo_w;
                        remainder   <= rem_w;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state_reg   <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=4): latency, results, busy/done timing,
// ignored requests during a run, and reset abort.
`timescale 1ns/1ps
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int prev_q = 0;
    int prev_r = 0;

    seq_divider #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for done (bounded), check latency, results,
    // busy throughout, result hold during CALC, and the IDLE cycle after.
    task automatic run_div(input string tag, input int a, input int b,
                           input int exp_lat, input int exp_q, input int exp_r,
                           input int exp_z);
        int cyc;
        int busy_low;
        dividend = 4'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        busy_low = 0;
        if (exp_lat > 1) begin
            check({tag, "_hold_q"}, int'(quotient), prev_q);
            check({tag, "_hold_r"}, int'(remainder), prev_r);
        end
        while (!done && cyc < 40) begin
            if (!busy) busy_low++;
            tick();
            cyc++;
        end
        if (!busy) busy_low++;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_quotient"}, int'(quotient), exp_q);
        check({tag, "_remainder"}, int'(remainder), exp_r);
        check({tag, "_dbz"}, int'(div_by_zero), exp_z);
        check({tag, "_busy_low_cycles"}, busy_low, 0);
        $display("txn %s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b,
                 quotient, remainder, div_by_zero, cyc);
        tick();
        check({tag, "_done_after"}, int'(done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int first_lat;
        int got_q;
        int got_r;

        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd5;
        divisor  = 4'd0;
        tick();
        tick();
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        $display("txn reset: outputs cleared");

        run_div("d13_4", 13, 4, 5, 3, 1, 0);
        run_div("d3_9", 3, 9, 2, 0, 3, 0);
        run_div("d7_0", 7, 0, 1, 15, 7, 1);
        run_div("d15_1", 15, 1, 17, 15, 0, 0);
        run_div("d8_2", 8, 2, 6, 4, 0, 0);

        // Second request and operand changes during CALC must be ignored.
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        tick();
        start     = 1'b0;
        cyc       = 1;
        done_cnt  = 0;
        first_lat = 0;
        got_q     = -1;
        got_r     = -1;
        for (int i = 0; i < 14; i++) begin
            if (cyc == 2) begin
                dividend = 4'd6;
                divisor  = 4'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (first_lat == 0) begin
                    first_lat = cyc;
                    got_q     = int'(quotient);
                    got_r     = int'(remainder);
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("ignore_done_count", done_cnt, 1);
        check("ignore_latency", first_lat, 5);
        check("ignore_quotient", got_q, 3);
        check("ignore_remainder", got_r, 1);
        $display("txn ignore: q=%0d r=%0d pulses=%0d lat=%0d", got_q, got_r,
                 done_cnt, first_lat);

        // Reset during the 5th CALC cycle aborts without a done pulse.
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("abort_no_activity", done_cnt, 0);
        $display("txn abort: outputs cleared, no done");
        prev_q = 0;
        prev_r = 0;

        run_div("d9_2", 9, 2, 6, 4, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider using repeated subtraction; the inverse of the team's repeated-addition product block.
- Accepts one dividend/divisor pair per start pulse and iterates one subtraction per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Sits beside the arithmetic helpers as the division path for small-width datapaths.

Parameters:
- N, 4, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  N  unsigned dividend, captured on accepted start
- divisor  input  N  unsigned divisor, captured on accepted start
- quotient  output  N  registered result, valid from done onward
- remainder  output  N  registered result, valid from done onward
- div_by_zero  output  1  registered flag, valid from done onward
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse, high only in DONE

Behaviour:
- Reset is synchronous: rst high at an edge forces state IDLE and clears all of the following to 0:
  - quotient, remainder, div_by_zero, busy, done;
  - internal working registers rem_w, quo_w, div_w.
- Reset mid-operation aborts the division. No done pulse is produced.
- States are IDLE, CALC and DONE.
- IDLE, on start=1:
  - Capture div_w<=divisor, rem_w<=dividend, quo_w<=0.
  - If divisor==0, go to DONE and load quotient<=all ones, remainder<=dividend, div_by_zero<=1.
  - Otherwise go to CALC.
- IDLE, on start=0: hold.
- CALC: one comparison per cycle.
  - If rem_w >= div_w: rem_w<=rem_w-div_w, quo_w<=quo_w+1, stay in CALC.
  - Else: load quotient<=quo_w, remainder<=rem_w, div_by_zero<=0, go to DONE.
- DONE: done=1 for exactly this cycle, then return to IDLE unconditionally.
- start asserted in CALC or DONE is ignored, with no queuing. Operand changes after capture have no effect.
- Result outputs hold their last values until the next result load, and also during the following CALC.
- Latency, with start accepted at edge E0:
  - Nonzero divisor: done is high in the cycle after edge E(q+1), i.e. q+2 cycles after acceptance, where q is the quotient.
  - Zero divisor: done is high in the cycle after E0, i.e. 1 cycle.
- Worst case is dividend=2^N-1, divisor=1: quotient=2^N-1 fits in N bits, latency 2^N+1 cycles. No overflow is possible.
- Arithmetic widths:
  - All comparison and subtraction is unsigned N-bit.
  - The rem_w >= div_w guard guarantees no borrow.
  - quo_w never exceeds 2^N-1.
- busy is high in CALC and DONE and low in IDLE. busy is a registered output derived from the next state.
- The next start can be accepted in the cycle immediately after DONE.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package div_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - default width constant DIV_N=4.
- No sub-module. The compare/subtract is a single expression and the FSM plus datapath stays in one module.

Test Plan:
- dividend=13, divisor=4, start 1 cycle -> done in 5th cycle after acceptance, quotient=3, remainder=1, div_by_zero=0, busy high for 5 cycles.
- dividend=3, divisor=9 -> done 2 cycles after acceptance, quotient=0, remainder=3.
- dividend=7, divisor=0 -> done 1 cycle after acceptance, quotient=4'hF, remainder=7, div_by_zero=1.
- dividend=15, divisor=1 -> done 17 cycles after acceptance, quotient=15, remainder=0. Then immediately start 8/2 the cycle after done -> quotient=4, remainder=0.
- Start 13/4; pulse start with 6/3 during CALC; change operand inputs mid-run -> result still 3 rem 1, second request ignored, exactly one done pulse.
- Start 15/1; assert rst for 1 cycle at the 5th CALC cycle -> all outputs 0 next cycle, no done pulse. A subsequent start of 9/2 gives quotient=4, remainder=1.
